// File: rtl/la_input_router_if.sv
// LA host-to-team bundle: mgmt-side select/data/enable in, per-team routed data and strobes out.
interface la_input_router_if #(
    parameter int NUM_TEAMS = 12
);
    logic [3:0]                    la_sel;
    logic [31:0]                   la_data_in;
    logic [31:0]                   la_oenb;
    logic [32*(NUM_TEAMS+1)-1:0]   designs_la_data_in_flat;
    logic [NUM_TEAMS:0]            la_update;
    logic                          la_active;

    modport master (
        output la_sel, la_data_in, la_oenb,
        input  designs_la_data_in_flat, la_update, la_active
    );

    modport slave (
        input  la_sel, la_data_in, la_oenb,
        output designs_la_data_in_flat, la_update, la_active
    );
endinterface

// File: rtl/la_input_router.sv
// Routes the masked LA input bus to one team slot, blanking all slots for a guard window
// after every selection change and strobing la_update when a team's routed value changes.
module la_input_router_slot (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_load,
    input  logic        i_first,
    input  logic [31:0] i_data,
    output logic [31:0] o_slot,
    output logic        o_update
);
    logic [31:0] r_slot;
    logic        r_update;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_slot   <= '0;
            r_update <= 1'b0;
        end else if (i_load) begin
            r_slot   <= i_data;
            r_update <= i_first | (i_data != r_slot);
        end else begin
            r_slot   <= '0;
            r_update <= 1'b0;
        end
    end

    assign o_slot   = r_slot;
    assign o_update = r_update;
endmodule

module la_input_router #(
    parameter int NUM_TEAMS    = 12,
    parameter int GUARD_CYCLES = 4
) (
    input  logic clk,
    input  logic nrst,
    la_input_router_if.slave bus
);
    localparam int              CW       = $clog2(GUARD_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [3:0]      MAX_SEL  = 4'(NUM_TEAMS);

    typedef enum logic {ST_BLANK, ST_ACTIVE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [31:0]         r_data_q;
    logic [3:0]          r_sel_q;
    logic                r_prev_blank;

    logic                w_change;
    logic                w_in_range;
    logic                w_load;
    logic [NUM_TEAMS:0][31:0] w_slots;
    logic [NUM_TEAMS:0]  w_upd;

    assign w_change   = (bus.la_sel != r_sel_q);
    assign w_in_range = (r_sel_q <= MAX_SEL);
    // Any blanking condition zeroes every slot, so only a settled in-range selection loads.
    assign w_load     = !w_change && (r_state == ST_ACTIVE) && w_in_range;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_BLANK;
            r_cnt        <= CNT_LOAD;
            r_data_q     <= '0;
            r_sel_q      <= '0;
            r_prev_blank <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_data_q     <= bus.la_data_in & ~bus.la_oenb;
            r_sel_q      <= bus.la_sel;
            r_prev_blank <= (r_state == ST_BLANK);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_change) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = CNT_LOAD;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == '0) w_state_nxt = ST_ACTIVE;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k <= NUM_TEAMS; k++) begin : g_slot
            la_input_router_slot u_slot (
                .clk      (clk),
                .nrst     (nrst),
                .i_load   (w_load && (r_sel_q == 4'(k))),
                .i_first  (r_prev_blank),
                .i_data   (r_data_q),
                .o_slot   (w_slots[k]),
                .o_update (w_upd[k])
            );
        end
    endgenerate

    assign bus.designs_la_data_in_flat = w_slots;
    assign bus.la_update               = w_upd;
    assign bus.la_active               = (r_state == ST_ACTIVE) && w_in_range;
endmodule

// File: tb/tb_la_input_router.sv
// Directed bench for la_input_router: stimulus queues expected strobes, a monitor checks them.
module tb_la_input_router;
    localparam int NT = 12;
    localparam int G  = 4;
    localparam int W  = 32*(NT+1);

    typedef struct packed {
        logic [3:0]  team;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    la_input_router_if #(.NUM_TEAMS(NT)) bus ();
    la_input_router #(.NUM_TEAMS(NT), .GUARD_CYCLES(G)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [W-1:0] slot_vec(int k, logic [31:0] d);
        logic [W-1:0] v;
        v = '0;
        v[k*32 +: 32] = d;
        return v;
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_flat(string nm, logic [W-1:0] exp);
        tests++;
        if (bus.designs_la_data_in_flat !== exp) begin
            fails++;
            $display("FAIL %s: flat got %h want %h", nm, bus.designs_la_data_in_flat, exp);
        end
    endtask

    task automatic chk_upd(string nm, logic [NT:0] exp);
        tests++;
        if (bus.la_update !== exp) begin
            fails++;
            $display("FAIL %s: la_update got %b want %b", nm, bus.la_update, exp);
        end
    endtask

    task automatic chk_act(string nm, logic exp);
        tests++;
        if (bus.la_active !== exp) begin
            fails++;
            $display("FAIL %s: la_active got %b want %b", nm, bus.la_active, exp);
        end
    endtask

    task automatic push(int team, logic [31:0] d);
        exp_t e;
        e.team = 4'(team);
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must be one-hot and match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        int   idx;
        if (nrst && bus.la_update != '0) begin
            tests++;
            idx = -1;
            for (int b = 0; b <= NT; b++) if (bus.la_update[b]) idx = b;
            if ($countones(bus.la_update) != 1) begin
                fails++;
                $display("FAIL upd_onehot: la_update got %b want one bit", bus.la_update);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: team %0d got strobe want none", idx);
            end else begin
                e = sb.pop_front();
                if (idx != int'(e.team) ||
                    bus.designs_la_data_in_flat !== slot_vec(int'(e.team), e.data)) begin
                    fails++;
                    $display("FAIL strobe_data: team %0d flat %h want team %0d data %h",
                             idx, bus.designs_la_data_in_flat, e.team, e.data);
                end
            end
        end
    end

    initial begin
        bus.la_sel     = 4'd0;
        bus.la_data_in = 32'hA5A5_0001;
        bus.la_oenb    = 32'h0;
        tick(2);
        chk_flat("reset_flat", '0);
        chk_upd("reset_upd", '0);
        chk_act("reset_act", 1'b0);

        // 1: first load after reset release
        nrst = 1'b1;
        push(0, 32'hA5A5_0001);
        tick(4);
        chk_flat("t1_blank_e4", '0);
        tick(1);
        chk_flat("t1_slot0_e5", slot_vec(0, 32'hA5A5_0001));
        chk_upd("t1_upd_e5", 13'b1);
        tick(1);
        chk_upd("t1_upd_once", '0);

        // 2: steady team 3, data change
        bus.la_sel     = 4'd3;
        bus.la_data_in = 32'h11;
        push(3, 32'h11);
        tick(1);
        chk_flat("t2_old_cleared", '0);
        tick(5);
        chk_flat("t2_slot3_11", slot_vec(3, 32'h11));
        tick(3);
        bus.la_data_in = 32'h22;
        push(3, 32'h22);
        tick(1);
        chk_flat("t2_latency_e", slot_vec(3, 32'h11));
        tick(1);
        chk_flat("t2_slot3_22", slot_vec(3, 32'h22));
        chk_upd("t2_upd3", 13'b1 << 3);
        tick(4);
        chk_upd("t2_hold_quiet", '0);

        // 3: 3 -> 7
        bus.la_sel = 4'd7;
        push(7, 32'h22);
        tick(1);
        chk_flat("t3_e0_zero", '0);
        chk_act("t3_e0_act", 1'b0);
        tick(3);
        chk_flat("t3_e3_zero", '0);
        chk_act("t3_e3_act", 1'b0);
        tick(1);
        chk_flat("t3_e4_zero", '0);
        tick(1);
        chk_flat("t3_slot7_e5", slot_vec(7, 32'h22));
        chk_act("t3_e5_act", 1'b1);

        // 4: window restart 2 -> 5 -> 9
        bus.la_sel     = 4'd2;
        bus.la_data_in = 32'h0000_2222;
        push(2, 32'h0000_2222);
        tick(6);
        chk_flat("t4_slot2", slot_vec(2, 32'h0000_2222));
        bus.la_sel = 4'd5;
        tick(1);
        chk_flat("t4_e0_zero", '0);
        tick(1);
        bus.la_sel     = 4'd9;
        bus.la_data_in = 32'h9999_0009;
        push(9, 32'h9999_0009);
        tick(1);
        chk_flat("t4_e2_zero", '0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_flat("t4_restart_zero", '0);
        end
        tick(1);
        chk_flat("t4_slot9_e7", slot_vec(9, 32'h9999_0009));

        // 5: bitwise oenb masking
        bus.la_sel     = 4'd1;
        bus.la_oenb    = 32'hFFFF_0000;
        bus.la_data_in = 32'hFFFF_FFFF;
        push(1, 32'h0000_FFFF);
        tick(6);
        chk_flat("t5_mask_hi", slot_vec(1, 32'h0000_FFFF));
        bus.la_oenb = 32'h0000_FFFF;
        push(1, 32'hFFFF_0000);
        tick(2);
        chk_flat("t5_mask_lo", slot_vec(1, 32'hFFFF_0000));

        // 6: out-of-range select, then reset while active
        bus.la_sel  = 4'd14;
        bus.la_oenb = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk_flat("t6_oor_flat", '0);
            chk_upd("t6_oor_upd", '0);
            chk_act("t6_oor_act", 1'b0);
        end
        bus.la_sel     = 4'd6;
        bus.la_data_in = 32'h66;
        push(6, 32'h66);
        tick(6);
        chk_flat("t6_slot6", slot_vec(6, 32'h66));
        tick(2);
        #2;
        nrst       = 1'b0;
        bus.la_sel = 4'd0;
        #1;
        chk_flat("t6_rst_flat", '0);
        chk_upd("t6_rst_upd", '0);
        chk_act("t6_rst_act", 1'b0);
        tick(1);
        nrst = 1'b1;
        push(0, 32'h66);
        tick(4);
        chk_flat("t6_post_rst_e4", '0);
        tick(1);
        chk_flat("t6_slot0_e5", slot_vec(0, 32'h66));

        tick(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d strobes missing want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
